// File: rtl/routing_pkg.sv
// Shared constants, loader state type and sizing helper for the configurable routing row.
package routing_pkg;

  localparam int unsigned SEL_PER_WIRE = 12;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFull
  } loader_state_e;

  function automatic int unsigned cfg_words(input int unsigned bits, input int unsigned word);
    return (bits + word - 1) / word;
  endfunction

endpackage

// File: rtl/bidir_routing_block.sv
// One switch box: each wire may be driven onto any other side under control of its 12 select bits.
module bidir_routing_block
  import routing_pkg::*;
#(
  parameter int unsigned WIRE_WIDTH = 3
) (
  input  logic [WIRE_WIDTH*SEL_PER_WIRE-1:0] sel,
  inout  wire  [WIRE_WIDTH-1:0]              left,
  inout  wire  [WIRE_WIDTH-1:0]              right,
  inout  wire  [WIRE_WIDTH-1:0]              top,
  inout  wire  [WIRE_WIDTH-1:0]              bottom
);

  // Per-wire select layout, source->dest:
  // 0 L->R, 1 L->T, 2 L->B, 3 R->L, 4 R->T, 5 R->B,
  // 6 T->L, 7 T->R, 8 T->B, 9 B->L, 10 B->R, 11 B->T
  for (genvar i = 0; i < WIRE_WIDTH; i++) begin : g_wire
    logic [SEL_PER_WIRE-1:0] s;
    assign s = sel[i*SEL_PER_WIRE +: SEL_PER_WIRE];

    assign right[i]  = (s[0] | s[7] | s[10]) ?
                       ((s[0] & left[i]) | (s[7] & top[i]) | (s[10] & bottom[i])) : 1'bz;
    assign left[i]   = (s[3] | s[6] | s[9]) ?
                       ((s[3] & right[i]) | (s[6] & top[i]) | (s[9] & bottom[i])) : 1'bz;
    assign top[i]    = (s[1] | s[4] | s[11]) ?
                       ((s[1] & left[i]) | (s[4] & right[i]) | (s[11] & bottom[i])) : 1'bz;
    assign bottom[i] = (s[2] | s[5] | s[8]) ?
                       ((s[2] & left[i]) | (s[5] & right[i]) | (s[8] & top[i])) : 1'bz;
  end

endmodule

// File: rtl/routing_cfg_loader.sv
// Streams configuration words into a shadow register and commits them atomically to the active set.
module routing_cfg_loader
  import routing_pkg::*;
#(
  parameter int unsigned CFG_BITS = 180,
  parameter int unsigned CFG_WORD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CFG_WORD-1:0] cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_commit,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic                row_live,
  output logic [CFG_BITS-1:0] sel
);

  localparam int unsigned CFG_WORDS = cfg_words(CFG_BITS, CFG_WORD);
  localparam int unsigned PAD_BITS  = CFG_WORDS * CFG_WORD;
  localparam int unsigned CNT_W     = $clog2(CFG_WORDS + 1);

  loader_state_e       state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                live_q, live_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [PAD_BITS-1:0] shadow_pad;
  logic [31:0]         base;
  logic                accept;

  // Ready is held low through reset and never looks at cfg_valid.
  assign cfg_ready = rst_n && (state_q != StFull);
  assign accept    = cfg_valid && (state_q != StFull);
  assign base      = 32'(count_q) * CFG_WORD;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    live_d     = live_q;
    done_d     = 1'b0;
    err_d      = err_q;
    shadow_pad = '0;
    shadow_pad[CFG_BITS-1:0] = shadow_q;

    if (cfg_commit) begin
      // Commit takes priority over any beat presented in the same cycle.
      if (state_q == StFull) begin
        active_d = shadow_q;
        live_d   = 1'b1;
        done_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d = StIdle;
      count_d = '0;
    end else if (accept) begin
      // Bits of the final word beyond CFG_BITS fall off the padded copy.
      shadow_pad[base +: CFG_WORD] = cfg_data;
      shadow_d = shadow_pad[CFG_BITS-1:0];
      count_d  = count_q + 1'b1;
      state_d  = (count_q == CNT_W'(CFG_WORDS - 1)) ? StFull : StLoad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      live_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      live_q   <= live_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign row_live = live_q;
  assign sel      = live_q ? active_q : '0;

endmodule

// File: rtl/routing_row_cfg.sv
// Bottom-edge row of routing blocks whose select bits come from the on-chip configuration loader.
module routing_row_cfg
  import routing_pkg::*;
#(
  parameter int unsigned WIRE_WIDTH = 3,
  parameter int unsigned FPGA_WIDTH = 5,
  parameter int unsigned CFG_WORD   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CFG_WORD-1:0]              cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic                             cfg_commit,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic                             row_live,
  inout  wire  [WIRE_WIDTH-1:0]            left,
  inout  wire  [WIRE_WIDTH-1:0]            right,
  inout  wire  [WIRE_WIDTH*FPGA_WIDTH-1:0] top,
  inout  wire  [WIRE_WIDTH*FPGA_WIDTH-1:0] bottom
);

  localparam int unsigned CFG_BITS  = FPGA_WIDTH * WIRE_WIDTH * SEL_PER_WIRE;
  localparam int unsigned BLK_BITS  = WIRE_WIDTH * SEL_PER_WIRE;
  localparam int unsigned LINK_BITS = (FPGA_WIDTH > 1) ? (FPGA_WIDTH - 1) * WIRE_WIDTH
                                                       : WIRE_WIDTH;

  logic [CFG_BITS-1:0]  sel_bus;
  wire  [LINK_BITS-1:0] link;

  routing_cfg_loader #(
    .CFG_BITS (CFG_BITS),
    .CFG_WORD (CFG_WORD)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_commit (cfg_commit),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .row_live   (row_live),
    .sel        (sel_bus)
  );

  // Link x joins block x right to block x+1 left.
  for (genvar x = 0; x < FPGA_WIDTH; x++) begin : g_col
    if (FPGA_WIDTH == 1) begin : g_only
      bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_blk (
        .sel    (sel_bus[x*BLK_BITS +: BLK_BITS]),
        .left   (left),
        .right  (right),
        .top    (top[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .bottom (bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
      );
    end else if (x == 0) begin : g_first
      bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_blk (
        .sel    (sel_bus[x*BLK_BITS +: BLK_BITS]),
        .left   (left),
        .right  (link[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .top    (top[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .bottom (bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
      );
    end else if (x == FPGA_WIDTH - 1) begin : g_last
      bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_blk (
        .sel    (sel_bus[x*BLK_BITS +: BLK_BITS]),
        .left   (link[(x-1)*WIRE_WIDTH +: WIRE_WIDTH]),
        .right  (right),
        .top    (top[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .bottom (bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
      );
    end else begin : g_mid
      bidir_routing_block #(.WIRE_WIDTH(WIRE_WIDTH)) u_blk (
        .sel    (sel_bus[x*BLK_BITS +: BLK_BITS]),
        .left   (link[(x-1)*WIRE_WIDTH +: WIRE_WIDTH]),
        .right  (link[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .top    (top[x*WIRE_WIDTH +: WIRE_WIDTH]),
        .bottom (bottom[x*WIRE_WIDTH +: WIRE_WIDTH])
      );
    end
  end

endmodule
